// File: rtl/seq_arb_pkg.sv
// Shared types and flag positions for the sequential-datapath arbiter.
// The arbiter RTL and its testbench both use this package.
package seq_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    WAIT2 = 3'd2,
    WAIT3 = 3'd3,
    FIN   = 3'd4,
    ABORT = 3'd5
  } arb_state_t;

  localparam int FLAG_SEL_BIT  = 2;
  localparam int FLAG_DONE_BIT = 3;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the winner is the first set req bit found
// by searching upward from ptr+1 and wrapping modulo N_REQ.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    idx,
  output logic             valid
);

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    // Offset 1..N_REQ puts ptr itself last, so the most recent owner has the lowest priority.
    for (int i = 1; i <= N_REQ; i++) begin
      if (!valid && req[(int'(ptr) + i) % N_REQ]) begin
        valid = 1'b1;
        idx   = IW'((int'(ptr) + i) % N_REQ);
      end
    end
    if (valid) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/seq_arbiter.sv
// Shares one sequential datapath between N_REQ requesters. Each job clears the
// datapath, waits for flag 2 (pulsing select), then waits for flag 3, guarded by a watchdog.
module seq_arbiter
  import seq_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DW      = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_REQ-1:0]  req,
  input  logic [N_REQ*DW-1:0] d_in,
  output logic [N_REQ-1:0]  grant,
  output logic [N_REQ-1:0]  done,
  output logic [N_REQ-1:0]  err,
  output logic              dp_reset,
  output logic              dp_select,
  output logic [DW-1:0]     dp_d,
  input  logic [DW-1:0]     dp_out
);

  localparam int IW = $clog2(N_REQ);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT - 1);

  arb_state_t           state_q, state_d;
  logic [N_REQ-1:0]     grant_q, grant_d;
  logic [DW-1:0]        dp_d_q, dp_d_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [IW-1:0]        own_q, own_d;
  logic [WW-1:0]        wdog_q, wdog_d;

  logic [N_REQ-1:0]         arb_gnt;
  logic [IW-1:0]            arb_idx;
  logic                     arb_valid;
  logic [N_REQ-1:0][DW-1:0] d_vec;
  logic                     flag_sel, flag_done;
  logic                     dp_out_unused;

  assign d_vec         = d_in;
  assign flag_sel      = dp_out[FLAG_SEL_BIT];
  assign flag_done     = dp_out[FLAG_DONE_BIT];
  assign dp_out_unused = ^dp_out;

  rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_rr (
    .req   (req),
    .ptr   (ptr_q),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    dp_d_d  = dp_d_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    wdog_d  = wdog_q;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          grant_d = arb_gnt;
          own_d   = arb_idx;
          dp_d_d  = d_vec[arb_idx];
          state_d = CLR;
        end
      end
      CLR: begin
        wdog_d  = '0;
        state_d = WAIT2;
      end
      WAIT2: begin
        if (flag_sel) begin
          wdog_d  = '0;
          state_d = WAIT3;
        end else if (wdog_q == WDOG_LAST) begin
          state_d = ABORT;
        end else begin
          wdog_d = wdog_q + WW'(1);
        end
      end
      WAIT3: begin
        // Flag 3 is only honoured here, which enforces the 2-then-3 ordering.
        if (flag_done) begin
          state_d = FIN;
        end else if (wdog_q == WDOG_LAST) begin
          state_d = ABORT;
        end else begin
          wdog_d = wdog_q + WW'(1);
        end
      end
      FIN, ABORT: begin
        ptr_d   = own_q;
        grant_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      dp_d_q  <= '0;
      ptr_q   <= IW'(N_REQ - 1);
      own_q   <= '0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      dp_d_q  <= dp_d_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      wdog_q  <= wdog_d;
    end
  end

  // Pulses come only from registered state, so an async reset kills them at once.
  always_comb begin
    grant     = grant_q;
    dp_d      = dp_d_q;
    dp_reset  = (state_q == CLR) || (state_q == ABORT);
    dp_select = (state_q == WAIT2) && flag_sel;
    done      = (state_q == FIN)   ? grant_q : '0;
    err       = (state_q == ABORT) ? grant_q : '0;
  end

endmodule

// File: tb/tb_seq_arbiter.sv
// Directed bench for seq_arbiter with a small datapath model whose flags rise
// a programmable number of cycles after each datapath clear.
module tb_seq_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int TO = 8;
  localparam int NEVER = 1000;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req;
  logic [N*DW-1:0] d_in;
  logic [N-1:0]  grant, done, err;
  logic          dp_reset, dp_select;
  logic [DW-1:0] dp_d, dp_out;

  int n_cmp = 0;
  int n_err = 0;

  // Datapath model: cycles since the last dp_reset; flags rise at d2 / d3.
  int cnt = 0;
  int d2 = 0;
  int d3 = 0;
  always @(posedge clk) begin
    if (dp_reset) cnt <= 0;
    else if (cnt < 200) cnt <= cnt + 1;
  end
  assign dp_out = {12'h000, (cnt >= d3), (cnt >= d2), 2'b00};

  always #5 clk = ~clk;

  seq_arbiter #(.N_REQ(N), .DW(DW), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .d_in      (d_in),
    .grant     (grant),
    .done      (done),
    .err       (err),
    .dp_reset  (dp_reset),
    .dp_select (dp_select),
    .dp_d      (dp_d),
    .dp_out    (dp_out)
  );

  // Observation of one job, sampled on falling edges until done or err shows.
  logic [N-1:0]  o_grant, o_done, o_err;
  logic [DW-1:0] o_dpd_grant, o_dpd_end;
  logic          o_term, o_rst_end;
  int            o_gcyc, o_tcyc, o_nsel, o_nrst;

  task automatic observe(input int maxc, input bit mutate);
    int c;
    c = 0;
    o_grant = '0; o_done = '0; o_err = '0; o_term = 1'b0; o_rst_end = 1'b0;
    o_dpd_grant = '0; o_dpd_end = '0; o_gcyc = 0; o_tcyc = 0; o_nsel = 0; o_nrst = 0;
    while (!o_term && c < maxc) begin
      @(negedge clk);
      c++;
      if (dp_select) o_nsel++;
      if (dp_reset) o_nrst++;
      if (grant != '0 && o_grant == '0) begin
        o_grant = grant; o_gcyc = c; o_dpd_grant = dp_d;
        if (mutate) begin
          req = '0;
          d_in[2*DW +: DW] = 16'h5678;
        end
      end
      if ((done | err) != '0) begin
        o_done = done; o_err = err; o_tcyc = c; o_term = 1'b1;
        o_rst_end = dp_reset; o_dpd_end = dp_d;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; req = '0; d_in = '0; d2 = 0; d3 = 0;
    repeat (2) @(negedge clk);
    n_cmp++; if ({grant, done, err, dp_reset, dp_select, dp_d} !== '0) begin n_err++;
      $display("FAIL reset_outputs got g=%b d=%b e=%b r=%b s=%b dpd=%h want all 0", grant, done, err, dp_reset, dp_select, dp_d); end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (grant !== '0 || dp_reset !== 1'b0) begin n_err++;
      $display("FAIL idle_no_req got g=%b r=%b want 0 0", grant, dp_reset); end
  endtask

  task automatic test_single();
    d_in[1*DW +: DW] = 16'hBEEF; d2 = 3; d3 = 5; req = 4'b0010;
    observe(40, 1'b0);
    n_cmp++; if (o_term !== 1'b1) begin n_err++; $display("FAIL single_timeout got %b want 1", o_term); end
    n_cmp++; if (o_grant !== 4'b0010) begin n_err++; $display("FAIL single_grant got %b want 0010", o_grant); end
    n_cmp++; if (o_gcyc !== 1) begin n_err++; $display("FAIL single_grant_lat got %0d want 1", o_gcyc); end
    n_cmp++; if (o_dpd_grant !== 16'hBEEF) begin n_err++; $display("FAIL single_dp_d got %h want beef", o_dpd_grant); end
    n_cmp++; if (o_nrst !== 1) begin n_err++; $display("FAIL single_dp_reset_cnt got %0d want 1", o_nrst); end
    n_cmp++; if (o_nsel !== 1) begin n_err++; $display("FAIL single_select_cnt got %0d want 1", o_nsel); end
    n_cmp++; if (o_done !== 4'b0010 || o_err !== 4'b0000) begin n_err++;
      $display("FAIL single_done got done=%b err=%b want 0010 0000", o_done, o_err); end
    n_cmp++; if (o_tcyc - o_gcyc !== 7) begin n_err++; $display("FAIL single_job_len got %0d want 7", o_tcyc - o_gcyc); end
    req = '0;
    @(negedge clk);
    n_cmp++; if (done !== '0 || grant !== '0) begin n_err++;
      $display("FAIL single_after got done=%b grant=%b want 0 0", done, grant); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_g;
    int idx;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < N; i++) d_in[i*DW +: DW] = DW'(16'hA000 + i);
    d2 = 0; d3 = 0; req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      idx = k % N;
      exp_g = '0; exp_g[idx] = 1'b1;
      observe(20, 1'b0);
      n_cmp++; if (o_grant !== exp_g || o_done !== exp_g) begin n_err++;
        $display("FAIL rr_job%0d got grant=%b done=%b want %b", k, o_grant, o_done, exp_g); end
      n_cmp++; if (o_dpd_grant !== DW'(16'hA000 + idx)) begin n_err++;
        $display("FAIL rr_dp_d%0d got %h want %h", k, o_dpd_grant, 16'hA000 + idx); end
      n_cmp++; if (o_gcyc !== ((k == 0) ? 1 : 2) || o_tcyc - o_gcyc !== 3) begin n_err++;
        $display("FAIL rr_timing%0d got gcyc=%0d len=%0d want %0d 3", k, o_gcyc, o_tcyc - o_gcyc, (k == 0) ? 1 : 2); end
    end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_watchdog();
    d2 = NEVER; d3 = NEVER; req = 4'b0101;
    observe(40, 1'b0);
    n_cmp++; if (o_grant !== 4'b0100) begin n_err++; $display("FAIL wd_grant got %b want 0100", o_grant); end
    n_cmp++; if (o_err !== 4'b0100 || o_done !== 4'b0000) begin n_err++;
      $display("FAIL wd_err got err=%b done=%b want 0100 0000", o_err, o_done); end
    n_cmp++; if (o_tcyc - o_gcyc !== TO + 1) begin n_err++; $display("FAIL wd_delay got %0d want %0d", o_tcyc - o_gcyc, TO + 1); end
    n_cmp++; if (o_rst_end !== 1'b1 || o_nrst !== 2) begin n_err++;
      $display("FAIL wd_dp_reset got end=%b cnt=%0d want 1 2", o_rst_end, o_nrst); end
    n_cmp++; if (o_nsel !== 0) begin n_err++; $display("FAIL wd_select got %0d want 0", o_nsel); end
    d2 = 0; d3 = 0;
    observe(20, 1'b0);
    n_cmp++; if (o_grant !== 4'b0001 || o_done !== 4'b0001 || o_gcyc !== 2) begin n_err++;
      $display("FAIL wd_next got grant=%b done=%b gcyc=%0d want 0001 0001 2", o_grant, o_done, o_gcyc); end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_flag_order();
    d2 = 4; d3 = 1; req = 4'b1000;
    observe(40, 1'b0);
    n_cmp++; if (o_grant !== 4'b1000 || o_done !== 4'b1000) begin n_err++;
      $display("FAIL order_done got grant=%b done=%b want 1000 1000", o_grant, o_done); end
    n_cmp++; if (o_nsel !== 1) begin n_err++; $display("FAIL order_select got %0d want 1", o_nsel); end
    n_cmp++; if (o_tcyc - o_gcyc !== 7) begin n_err++; $display("FAIL order_job_len got %0d want 7", o_tcyc - o_gcyc); end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    d2 = 0; d3 = 0; req = 4'b0010;
    observe(20, 1'b0);
    n_cmp++; if (o_done !== 4'b0010) begin n_err++; $display("FAIL rmid_pre got %b want 0010", o_done); end
    req = '0;
    @(negedge clk);
    d3 = NEVER; req = 4'b0010;
    @(negedge clk);
    n_cmp++; if (grant !== 4'b0010) begin n_err++; $display("FAIL rmid_grant got %b want 0010", grant); end
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_cmp++; if ({grant, done, err, dp_reset, dp_select, dp_d} !== '0) begin n_err++;
      $display("FAIL rmid_async got g=%b d=%b e=%b r=%b s=%b dpd=%h want all 0", grant, done, err, dp_reset, dp_select, dp_d); end
    @(negedge clk);
    reset = 1'b1; d3 = 0; req = 4'b0110;
    observe(20, 1'b0);
    n_cmp++; if (o_grant !== 4'b0010 || o_done !== 4'b0010) begin n_err++;
      $display("FAIL rmid_ptr got grant=%b done=%b want 0010 0010", o_grant, o_done); end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_drop_req();
    int extra;
    d_in[2*DW +: DW] = 16'h1234; d2 = 3; d3 = 5; req = 4'b0100;
    observe(40, 1'b1);
    n_cmp++; if (o_grant !== 4'b0100) begin n_err++; $display("FAIL drop_grant got %b want 0100", o_grant); end
    n_cmp++; if (o_dpd_end !== 16'h1234) begin n_err++; $display("FAIL drop_dp_d got %h want 1234", o_dpd_end); end
    n_cmp++; if (o_done !== 4'b0100 || o_err !== 4'b0000) begin n_err++;
      $display("FAIL drop_done got done=%b err=%b want 0100 0000", o_done, o_err); end
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if ((done | err | grant) != '0) extra++;
    end
    n_cmp++; if (extra !== 0) begin n_err++; $display("FAIL drop_quiet got %0d active cycles want 0", extra); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_watchdog();
    test_flag_order();
    test_reset_mid();
    test_drop_req();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
